// File: rtl/sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl
//
// Multi-channel SAR ADC sequencer. Walks the enabled channels in ascending
// order. For each channel it:
//   - drives the analog mux and holds the sample/hold in track mode;
//   - runs a SIZE-bit successive-approximation search against the comparator;
//   - optionally averages 2^avg_log2 conversions.
// Each averaged result is presented on a valid/ready port together with its
// channel tag.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   start       start a scan (only honoured while idle)
//   continuous  1: rescan after the last channel, 0: single scan
//   ch_mask     channel enables, latched at scan start / rescan
//   avg_log2    averaging exponent n (2^n samples), latched with ch_mask
//   cmp         comparator result, 1 = Vin >= DAC
//   dac_out     trial code to the DAC
//   dac_outn    inverted trial code for an active-low DAC
//   clkn        inverted clock for a clocked comparator
//   ch_sel      analog mux select
//   sample      S/H track enable
//   busy        controller is not idle
//   res_valid   result available
//   res_ready   consumer accepts the result
//   res_data    averaged conversion result
//   res_ch      channel that res_data belongs to
//   scan_done   one-cycle pulse after the last result of a scan is accepted
// -----------------------------------------------------------------------------
module sar_seq_ctrl #(
    parameter int SIZE       = 8,
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int SAMPLE_CYC = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            continuous,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [1:0]      avg_log2,
    input  logic            cmp,
    output logic [SIZE-1:0] dac_out,
    output logic [SIZE-1:0] dac_outn,
    output logic            clkn,
    output logic [CHW-1:0]  ch_sel,
    output logic            sample,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SIZE-1:0] res_data,
    output logic [CHW-1:0]  res_ch,
    output logic            scan_done
);

    localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    // Eight full-scale codes are the worst case, so three guard bits suffice.
    localparam int AW = SIZE + 3;
    localparam logic [SIZE-1:0] MID = {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONV,
        ST_ACC,
        ST_OUT
    } state_t;

    state_t          state;
    logic [NCH-1:0]  mask_q;
    logic [1:0]      avg_q;
    logic [SW-1:0]   smp_cnt;
    logic [BW-1:0]   bit_idx;
    logic [3:0]      conv_cnt;
    logic [AW-1:0]   acc;

    logic [SIZE-1:0] dac_trial;
    logic [AW-1:0]   acc_sum;
    logic [3:0]      cnt_inc;
    logic [CHW:0]    nxt;

    // Lowest set bit of the mask; zero when the mask is empty.
    function automatic logic [CHW-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = CHW'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, returned as {found, index}.
    function automatic logic [CHW:0] next_ch(input logic [NCH-1:0] m,
                                             input logic [CHW-1:0] cur);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    // Average by shifting out the sample-count exponent; fraction is dropped.
    function automatic logic [SIZE-1:0] avg_trunc(input logic [AW-1:0] sum,
                                                  input logic [1:0]    n);
        logic [AW-1:0] q;
        q = sum >> n;
        return q[SIZE-1:0];
    endfunction

    // One binary-search step: drop the bit under test if the input is below
    // the trial level, then raise the next lower bit as the new trial.
    always_comb begin
        dac_trial = dac_out;
        if (!cmp) dac_trial[bit_idx] = 1'b0;
        if (bit_idx != '0) dac_trial[bit_idx - BW'(1)] = 1'b1;
    end

    assign acc_sum  = acc + AW'(dac_out);
    assign cnt_inc  = conv_cnt + 4'd1;
    assign nxt      = next_ch(mask_q, ch_sel);
    assign dac_outn = ~dac_out;
    assign clkn     = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            avg_q     <= '0;
            ch_sel    <= '0;
            smp_cnt   <= '0;
            bit_idx   <= '0;
            conv_cnt  <= '0;
            acc       <= '0;
            dac_out   <= MID;
            sample    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ch    <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                // Idle: wait for a start with at least one channel enabled
                ST_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        mask_q   <= ch_mask;
                        avg_q    <= avg_log2;
                        ch_sel   <= lowest_ch(ch_mask);
                        acc      <= '0;
                        conv_cnt <= '0;
                        smp_cnt  <= '0;
                        dac_out  <= MID;
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SAMPLE;
                    end
                end

                // Track: S/H follows the input for SAMPLE_CYC cycles
                ST_SAMPLE: begin
                    if (smp_cnt == SW'(SAMPLE_CYC - 1)) begin
                        sample  <= 1'b0;
                        bit_idx <= BW'(SIZE - 1);
                        state   <= ST_CONV;
                    end else begin
                        smp_cnt <= smp_cnt + SW'(1);
                    end
                end

                // Convert: one comparator decision per cycle, MSB first
                ST_CONV: begin
                    dac_out <= dac_trial;
                    if (bit_idx == '0) begin
                        state <= ST_ACC;
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end

                // Accumulate: either take another sample or publish the mean
                ST_ACC: begin
                    acc      <= acc_sum;
                    conv_cnt <= cnt_inc;
                    if (cnt_inc == (4'd1 << avg_q)) begin
                        res_data  <= avg_trunc(acc_sum, avg_q);
                        res_ch    <= ch_sel;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        smp_cnt <= '0;
                        dac_out <= MID;
                        sample  <= 1'b1;
                        state   <= ST_SAMPLE;
                    end
                end

                // Output: hold the result until the consumer takes it
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc       <= '0;
                        conv_cnt  <= '0;
                        smp_cnt   <= '0;
                        dac_out   <= MID;
                        if (nxt[CHW]) begin
                            ch_sel <= nxt[CHW-1:0];
                            sample <= 1'b1;
                            state  <= ST_SAMPLE;
                        end else begin
                            scan_done <= 1'b1;
                            // continuous and the mask are only looked at here,
                            // so a mid-scan change takes effect on the next scan.
                            if (continuous && (ch_mask != '0)) begin
                                mask_q <= ch_mask;
                                avg_q  <= avg_log2;
                                ch_sel <= lowest_ch(ch_mask);
                                sample <= 1'b1;
                                state  <= ST_SAMPLE;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_seq_ctrl
//
// Self-checking bench for sar_seq_ctrl. An ideal comparator is built from a
// per-conversion input voltage. A behavioural model predicts every output
// cycle by cycle:
//   - the result of each channel is the truncated mean of its input samples;
//   - results arrive a fixed number of cycles after a start or handshake;
//   - channels come in ascending mask order.
// Directed sequences pin the model with literal values. A randomized phase
// then exercises masks, averaging, back-pressure and continuous mode.
// -----------------------------------------------------------------------------
module tb_sar_seq_ctrl;

    localparam int SIZE = 8;
    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int SC   = 2;
    localparam int P    = SC + SIZE + 1;   // cycles per conversion
    localparam logic [SIZE-1:0] MID  = 8'h80;
    localparam logic [SIZE-1:0] MIDN = 8'h7F;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            continuous;
    logic [NCH-1:0]  ch_mask;
    logic [1:0]      avg_log2;
    logic            cmp;
    logic [SIZE-1:0] dac_out;
    logic [SIZE-1:0] dac_outn;
    logic            clkn;
    logic [CHW-1:0]  ch_sel;
    logic            sample;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [SIZE-1:0] res_data;
    logic [CHW-1:0]  res_ch;
    logic            scan_done;

    logic [SIZE-1:0] vin = '0;

    // Ideal comparator
    assign cmp = (vin >= dac_out);

    always #5 clk = ~clk;

    sar_seq_ctrl #(
        .SIZE(SIZE), .NCH(NCH), .CHW(CHW), .SAMPLE_CYC(SC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .avg_log2(avg_log2), .cmp(cmp),
        .dac_out(dac_out), .dac_outn(dac_outn), .clkn(clkn), .ch_sel(ch_sel),
        .sample(sample), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
        .scan_done(scan_done)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_busy  = 1'b0;
    bit              m_valid = 1'b0;
    bit              m_done  = 1'b0;
    int              m_cnt   = 0;     // rising edges left until the result shows
    int              m_n     = 0;     // averaging exponent of the running scan
    int              m_chq[$];        // channels still owed in this scan
    int              m_vins[8];       // input voltage for each sample of a result
    logic [SIZE-1:0] m_data  = '0;
    int              plan[$];         // forced input voltages, else random
    int              obs_ch[$];
    int              obs_data[$];

    function automatic int span(input int n);
        return (1 << n) * P;
    endfunction

    task automatic new_result();
        int sum;
        sum = 0;
        for (int k = 0; k < (1 << m_n); k++) begin
            if (plan.size() > 0) m_vins[k] = plan.pop_front();
            else                 m_vins[k] = int'($urandom_range(0, 255));
            sum += m_vins[k];
        end
        m_data = SIZE'(sum >> m_n);
        m_cnt  = span(m_n);
    endtask

    task automatic load_scan(input logic [NCH-1:0] m, input logic [1:0] n);
        m_chq.delete();
        for (int i = 0; i < NCH; i++) if (m[i]) m_chq.push_back(i);
        m_n = int'(n);
        new_result();
    endtask

    // Compare on the falling edge, then advance the model across the next
    // rising edge using the inputs that edge will see.
    always @(negedge clk) begin
        int el;
        int ph;
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_chq.delete();
            chk("rst_busy",      busy,      0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_sample",    sample,    0);
            chk("rst_scan_done", scan_done, 0);
            chk("rst_dac_out",   dac_out,   MID);
        end else begin
            chk("busy",      busy,      m_busy);
            chk("res_valid", res_valid, m_valid);
            chk("scan_done", scan_done, m_done);
            chk("clkn",      clkn,      1);
            if (m_busy) chk("ch_sel", ch_sel, m_chq[0]);
            if (m_valid) begin
                chk("res_data",   res_data, m_data);
                chk("res_ch",     res_ch,   m_chq[0]);
                chk("sample_out", sample,   0);
            end else if (m_busy) begin
                el = span(m_n) - m_cnt;
                ph = el % P;
                chk("sample", sample, (ph < SC) ? 1 : 0);
                if (ph < SC) begin
                    chk("dac_mid",  dac_out,  MID);
                    chk("dac_midn", dac_outn, MIDN);
                end
                if (ph == P - 1) begin
                    chk("code",  dac_out,  m_vins[el / P]);
                    chk("coden", dac_outn, ~m_vins[el / P] & 32'hFF);
                end
                vin = SIZE'(m_vins[el / P]);
            end else begin
                chk("sample_idle", sample, 0);
            end

            if (m_valid && res_ready) begin
                obs_ch.push_back(int'(res_ch));
                obs_data.push_back(int'(res_data));
            end

            m_done = 1'b0;
            if (!m_busy) begin
                if (start && (ch_mask != '0)) begin
                    load_scan(ch_mask, avg_log2);
                    m_busy = 1'b1;
                end
            end else if (m_valid) begin
                if (res_ready) begin
                    m_valid = 1'b0;
                    void'(m_chq.pop_front());
                    if (m_chq.size() > 0) begin
                        new_result();
                    end else begin
                        m_done = 1'b1;
                        if (continuous && (ch_mask != '0)) load_scan(ch_mask, avg_log2);
                        else                               m_busy = 1'b0;
                    end
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m, input logic [1:0] n);
        ch_mask  = m;
        avg_log2 = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 1000) begin
            step();
            cyc++;
        end
        chk("valid_seen", res_valid, 1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 5000) begin
            step();
            cyc++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_sample"},    sample,    0);
        chk({tag, "_scan_done"}, scan_done, 0);
        chk({tag, "_res_data"},  res_data,  0);
        chk({tag, "_res_ch"},    res_ch,    0);
        chk({tag, "_ch_sel"},    ch_sel,    0);
        chk({tag, "_dac_out"},   dac_out,   8'h80);
        chk({tag, "_dac_outn"},  dac_outn,  8'h7F);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n    = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        ch_mask    = '0;
        avg_log2   = '0;
        res_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // Single channel, no averaging: 0xA5 after 11 cycles
        plan.push_back(8'hA5);
        pulse_start(4'b0001, 2'd0);
        wait_valid(cyc);
        chk("t1_latency", cyc, 11);
        chk("t1_data", res_data, 8'hA5);
        chk("t1_ch", res_ch, 0);
        res_ready = 1'b1;
        step();
        chk("t1_scan_done", scan_done, 1);
        chk("t1_busy_low", busy, 0);
        step();
        chk("t1_done_pulse_end", scan_done, 0);

        // Sparse mask: only channels 1 and 3
        obs_ch.delete(); obs_data.delete();
        pulse_start(4'b1010, 2'd0);
        wait_idle();
        chk("t2_count", obs_ch.size(), 2);
        chk("t2_first", (obs_ch.size() > 0) ? obs_ch[0] : -1, 1);
        chk("t2_second", (obs_ch.size() > 1) ? obs_ch[1] : -1, 3);

        // Averaging over 4 samples: (0x10+0x11+0x12+0x13)>>2 = 0x11 at cycle 44
        res_ready = 1'b0;
        plan = '{8'h10, 8'h11, 8'h12, 8'h13};
        pulse_start(4'b0001, 2'd2);
        wait_valid(cyc);
        chk("t3_latency", cyc, 44);
        chk("t3_data", res_data, 8'h11);
        res_ready = 1'b1;
        wait_idle();

        // Averaging over 8 samples at both ends of the range
        for (int v = 0; v < 2; v++) begin
            obs_data.delete(); obs_ch.delete();
            for (int k = 0; k < 8; k++) plan.push_back((v == 0) ? 255 : 0);
            pulse_start(4'b0001, 2'd3);
            wait_idle();
            chk("t3_avg8", (obs_data.size() > 0) ? obs_data[0] : -1, (v == 0) ? 255 : 0);
        end

        // Back-pressure: result held for 20 cycles, no sampling meanwhile
        res_ready = 1'b0;
        plan = '{8'h3C, 8'hC3};
        pulse_start(4'b0011, 2'd0);
        wait_valid(cyc);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_data", res_data, 8'h3C);
            chk("t4_hold_ch", res_ch, 0);
            chk("t4_hold_sample", sample, 0);
        end
        res_ready = 1'b1;
        step();
        wait_valid(cyc);
        chk("t4_resume_latency", cyc, 11);
        chk("t4_resume_ch", res_ch, 1);
        chk("t4_resume_data", res_data, 8'hC3);
        wait_idle();

        // continuous dropped mid-scan, start while busy ignored
        obs_ch.delete(); obs_data.delete();
        continuous = 1'b1;
        pulse_start(4'b0011, 2'd0);
        step(); step();
        continuous = 1'b0;
        pulse_start(4'b0100, 2'd0);
        wait_idle();
        chk("t5_count", obs_ch.size(), 2);
        chk("t5_first", (obs_ch.size() > 0) ? obs_ch[0] : -1, 0);
        chk("t5_second", (obs_ch.size() > 1) ? obs_ch[1] : -1, 1);
        pulse_start(4'b0000, 2'd0);
        chk("t5_empty_mask_ignored", busy, 0);
        step();
        chk("t5_empty_mask_still_idle", busy, 0);

        // continuous rescans until released
        obs_ch.delete(); obs_data.delete();
        continuous = 1'b1;
        pulse_start(4'b0001, 2'd0);
        cyc = 0;
        while (obs_ch.size() < 3 && cyc < 200) begin
            step();
            cyc++;
        end
        continuous = 1'b0;
        wait_idle();
        chk("t5_rescans", (obs_ch.size() >= 3) ? 1 : 0, 1);

        // Reset in the middle of a conversion
        res_ready = 1'b0;
        plan.push_back(8'h5A);
        pulse_start(4'b0001, 2'd0);
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6");
        step();
        reset_n = 1'b1;
        step();
        plan.push_back(8'h77);
        pulse_start(4'b0001, 2'd0);
        wait_valid(cyc);
        chk("t6_after_latency", cyc, 11);
        chk("t6_after_data", res_data, 8'h77);
        res_ready = 1'b1;
        wait_idle();

        // Randomized traffic
        for (int it = 0; it < 4000; it++) begin
            start      = ($urandom_range(0, 9) == 0);
            ch_mask    = 4'($urandom);
            avg_log2   = 2'($urandom_range(0, 3));
            continuous = ($urandom_range(0, 3) == 0);
            res_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        start      = 1'b0;
        continuous = 1'b0;
        res_ready  = 1'b1;
        wait_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
